// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard MMIO controller: register map, bit
// positions and the break-code filter state type.
package kbd_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_RX_ERROR  = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 6;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FILTER = 1;
  localparam int CTRL_IRQ_EN = 2;

  typedef enum logic {
    FLT_PASS      = 1'b0,
    FLT_DROP_NEXT = 1'b1
  } flt_state_e;

endpackage

// File: rtl/kbd_scan_fifo.sv
// Scancode FIFO: power-of-two depth, wrapping pointers, head visible
// combinationally so the controller can register it on a read.
module kbd_scan_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  import kbd_pkg::*;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem[rd_ptr_q];

  // A push into a full FIFO only succeeds when an entry leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/kbd_mmio_ctrl.sv
// Memory-mapped PS/2 keyboard controller: optional break-code filtering,
// scancode FIFO, sticky error flags and a level interrupt.
module kbd_mmio_ctrl #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] F0_CODE    = 8'hF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  scancode,
  input  logic        scan_valid,
  input  logic        scan_err,
  input  logic [1:0]  addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  import kbd_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop;

  logic          enable_q, enable_d;
  logic          filter_q, filter_d;
  logic          irq_en_q, irq_en_d;
  logic          ovf_q, ovf_d;
  logic          rxerr_q, rxerr_d;
  logic [31:0]   rdata_q, rdata_d;
  flt_state_e    state_q, state_d;

  logic          ctrl_wr, status_wr, scan_ok;
  logic [31:0]   status_word;

  assign ctrl_wr   = we && (addr == ADDR_CTRL);
  assign status_wr = we && (addr == ADDR_STATUS);
  assign pop       = re && (addr == ADDR_DATA) && !empty;
  assign scan_ok   = scan_valid && enable_q;

  always_comb begin
    status_word = '0;
    status_word[ST_NOT_EMPTY] = !empty;
    status_word[ST_FULL]      = full;
    status_word[ST_OVERFLOW]  = ovf_q;
    status_word[ST_RX_ERROR]  = rxerr_q;
    status_word[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(count);
  end

  // Filter FSM: a CTRL write clearing enable or filter_break wins over a
  // same-cycle scancode so no stale DROP_NEXT survives the reconfiguration.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    if (scan_ok) begin
      if (!filter_q) begin
        push = 1'b1;
      end else begin
        case (state_q)
          FLT_PASS: begin
            if (scancode == F0_CODE) state_d = FLT_DROP_NEXT;
            else                     push    = 1'b1;
          end
          FLT_DROP_NEXT: state_d = FLT_PASS;
          default:       state_d = FLT_PASS;
        endcase
      end
    end
    if (ctrl_wr && (!wdata[CTRL_ENABLE] || !wdata[CTRL_FILTER])) state_d = FLT_PASS;
  end

  always_comb begin
    enable_d = enable_q;
    filter_d = filter_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr) begin
      enable_d = wdata[CTRL_ENABLE];
      filter_d = wdata[CTRL_FILTER];
      irq_en_d = wdata[CTRL_IRQ_EN];
    end
    // Set terms are ORed last so they beat a same-cycle write-1-to-clear.
    ovf_d   = (ovf_q && !(status_wr && wdata[ST_OVERFLOW])) || (push && full && !pop);
    rxerr_d = (rxerr_q && !(status_wr && wdata[ST_RX_ERROR])) || scan_err;

    rdata_d = rdata_q;
    if (re) begin
      case (addr)
        ADDR_DATA:   rdata_d = empty ? 32'h0 : {24'h0, head};
        ADDR_STATUS: rdata_d = status_word;
        ADDR_CTRL:   rdata_d = {29'h0, irq_en_q, filter_q, enable_q};
        default:     rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q <= 1'b1;
      filter_q <= 1'b1;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      rxerr_q  <= 1'b0;
      rdata_q  <= '0;
      state_q  <= FLT_PASS;
    end else begin
      enable_q <= enable_d;
      filter_q <= filter_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      rxerr_q  <= rxerr_d;
      rdata_q  <= rdata_d;
      state_q  <= state_d;
    end
  end

  kbd_scan_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (scancode),
    .pop   (pop),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign rdata = rdata_q;
  assign irq   = irq_en_q && (!empty || ovf_q || rxerr_q);

endmodule

// File: doc/kbd_mmio_ctrl.md
KBD_MMIO_CTRL -- requirements
Module: kbd_mmio_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, scancode FIFO entries (power of two, 2..32).
REQ-002 SHALL have parameter F0_CODE, default 8'hF0, break-prefix byte value.
REQ-003 SHALL have port clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port scancode  in  8  byte from the PS/2 receiver, valid only when scan_valid=1.
REQ-006 SHALL have port scan_valid  in  1  one-cycle strobe, new scancode.
REQ-007 SHALL have port scan_err  in  1  one-cycle strobe, receiver framing or parity error.
REQ-008 SHALL have port addr  in  2  word select: 0=DATA, 1=STATUS, 2=CTRL, 3=reserved.
REQ-009 SHALL have port re  in  1  CPU read strobe, one cycle per access.
REQ-010 SHALL have port we  in  1  CPU write strobe, one cycle per access.
REQ-011 SHALL have port wdata  in  32  CPU write data.
REQ-012 SHALL have port rdata  out  32  CPU read data, registered.
REQ-013 SHALL have port irq  out  1  level interrupt to the CPU.

Function
REQ-014 SHALL drive rdata the cycle after re=1: one-cycle read latency; rdata holds its value when re=0.
REQ-015 SHALL return DATA as {24'b0, head byte}; a DATA read with FIFO non-empty SHALL pop exactly one entry in the re cycle.
REQ-016 SHALL return 32'b0 for a DATA read while empty, with no pop and no flag change.
REQ-017 SHALL return STATUS as bit0=not_empty, bit1=full, bit2=overflow (sticky), bit3=rx_error (sticky), bits[9:4]=count, all other bits 0.
REQ-018 SHALL clear each sticky STATUS bit on a STATUS write with the matching wdata bit =1 (write-1-to-clear); other STATUS bits ignore writes.
REQ-019 SHALL return CTRL as bit0=enable, bit1=filter_break, bit2=irq_en; CTRL writes load these bits from wdata[2:0].
REQ-020 SHALL ignore writes to DATA and reserved; reads of reserved SHALL return 0.
REQ-021 SHALL discard scan_valid strobes while enable=0, and SHALL leave the filter FSM unchanged.
REQ-022 SHALL, with filter_break=0, push every enabled scancode unchanged.
REQ-023 SHALL, with filter_break=1, run an FSM with states PASS and DROP_NEXT: in PASS, F0_CODE moves to DROP_NEXT without a push, and any other byte is pushed; in DROP_NEXT, the next byte is dropped and the FSM returns to PASS.
REQ-024 SHALL force the filter FSM to PASS when filter_break is written 0 or enable is written 0.
REQ-025 SHALL, on a push while full with no simultaneous pop, drop the byte and set overflow; FIFO contents SHALL be unchanged.
REQ-026 SHALL, on a simultaneous push and pop, perform both; count is unchanged, and a push when full with a pop SHALL succeed with no overflow.
REQ-027 SHALL wrap read and write pointers modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-028 SHALL set rx_error on scan_err=1 regardless of enable; set takes priority over a same-cycle W1C clear. The same priority SHALL apply to overflow.
REQ-029 SHALL drive irq = irq_en & (not_empty | overflow | rx_error), combinational from registered state.
REQ-030 SHALL treat re and we asserted in the same cycle as both actions performed.

Reset
REQ-031 SHALL, on reset=0, asynchronously set: FIFO empty, pointers 0, count 0, overflow=0, rx_error=0, enable=1, filter_break=1, irq_en=0, FSM=PASS, rdata=0, irq=0.
REQ-032 SHALL, when reset is asserted mid-operation, discard all queued bytes and any pending DROP_NEXT state.

Structure
REQ-033 SHALL place in shared package kbd_pkg: register word indices, STATUS/CTRL bit positions, and the filter-state enum type.
REQ-034 SHALL implement storage as sub-module kbd_scan_fifo (push, pop, head, count, full, empty), parameterised by FIFO_DEPTH.

Verification
REQ-035 SHALL test: push 8'h1C, 8'hF0, 8'h1C with filter on, then read DATA twice -> first read 32'h1C, second 32'h0, STATUS bit0=0.
REQ-036 SHALL test: 9 scancodes 8'h01..8'h09 with depth 8 and no reads -> STATUS full=1, overflow=1, count=8; 8 DATA reads return 8'h01..8'h08.
REQ-037 SHALL test: FIFO full, push 8'h2A with a same-cycle DATA read -> overflow stays 0, count stays 8, last entry 8'h2A.
REQ-038 SHALL test: scan_err pulse, then STATUS write 32'h8 -> bit3 set then clear; irq=1 in between only when irq_en=1.
REQ-039 SHALL test: reset asserted with 3 entries and FSM in DROP_NEXT, then released and 8'h1C pushed -> count=1, DATA read=32'h1C.
REQ-040 SHALL test: CTRL write 32'h0, push 8'h1C -> count stays 0; CTRL write 32'h1, push 8'hF0 -> DATA read=32'hF0.
